pipeline_controller: RTL

Central hazard and sequencing controller for the five-stage MIPS pipeline. It watches the ID-stage decode fields, the EX-stage load destination, branch resolution, and the MEM-stage cache handshake. From these it drives the PC and pipeline-register enables, flushes and bubbles. It also sequences the halt instruction: it drains the pipeline, raises a final halted flag, and counts stall cycles for performance reporting.

---
 rtl/pipeline_controller_if.sv | 43 ++++
 rtl/pipeline_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_controller_if.sv
// Pipeline hazard/sequencing bus: ID/EX/MEM status in, stage enables out.
// Latency: none; the bundle carries only wires.
// Backpressure: carried by the enables; the stages hold whenever their enable is low.
interface pipeline_controller_if;
  // Stage status observed by the controller
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_jump;
  logic        id_halt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  // Controls and status driven by the controller
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_bubble;
  logic        back_write;
  logic        halted;
  logic        mem_error;
  logic [31:0] stall_count;

  // Pipeline side: drives stage status, consumes controls
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_halt,
           ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           back_write, halted, mem_error, stall_count
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_halt,
           ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           back_write, halted, mem_error, stall_count
  );
endinterface

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes, halt drain.
// Latency: enables are combinational (same cycle); state, halted, mem_error, stall_count registered.
// Backpressure: a pending cache access (mem_req && !mem_ready) freezes every stage.
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_b,
  pipeline_controller_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      state;
  logic        ret_drain;   // MEM_WAIT returns to DRAIN when set, else RUN
  logic [7:0]  wait_cnt;
  logic [3:0]  drain_cnt;
  logic        halted_q;
  logic        mem_error_q;
  logic [31:0] stall_cnt;

  logic        freeze;
  logic        eff_run;
  logic        eff_drain;
  logic        load_use;
  logic        halt_accept;
  logic [7:0]  wait_nxt;
  logic        pc_w;
  logic        if_id_w;
  logic        if_id_f;
  logic        id_ex_w;
  logic        id_ex_b;
  logic        back_w;

  assign freeze = bus.mem_req && !bus.mem_ready && (state != HALTED);

  // The unfrozen cycle that ends MEM_WAIT behaves exactly like a cycle of the
  // state being returned to, so it can accept a halt or count down the drain.
  assign eff_run   = (state == RUN)   || ((state == MEM_WAIT) && !ret_drain);
  assign eff_drain = (state == DRAIN) || ((state == MEM_WAIT) &&  ret_drain);

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  // The frozen cycle that enters MEM_WAIT is the first counted one.
  assign wait_nxt = (state == MEM_WAIT) ? (wait_cnt + 8'd1) : 8'd1;

  // Same-cycle enables, flush and bubble from state and stage status
  always_comb begin
    pc_w        = 1'b0;
    if_id_w     = 1'b0;
    if_id_f     = 1'b0;
    id_ex_w     = 1'b0;
    id_ex_b     = 1'b0;
    back_w      = 1'b0;
    halt_accept = 1'b0;
    if (!freeze) begin
      if (eff_drain) begin
        id_ex_w = 1'b1;
        id_ex_b = 1'b1;
        back_w  = 1'b1;
      end else if (eff_run) begin
        if (bus.ex_branch_taken) begin
          pc_w    = 1'b1;
          if_id_w = 1'b1;
          id_ex_w = 1'b1;
          back_w  = 1'b1;
          if_id_f = 1'b1;
          id_ex_b = 1'b1;
        end else if (load_use) begin
          id_ex_w = 1'b1;
          id_ex_b = 1'b1;
          back_w  = 1'b1;
        end else if (bus.id_halt) begin
          id_ex_w     = 1'b1;
          back_w      = 1'b1;
          halt_accept = 1'b1;
        end else begin
          pc_w    = 1'b1;
          if_id_w = 1'b1;
          id_ex_w = 1'b1;
          back_w  = 1'b1;
          if_id_f = bus.id_jump;
        end
      end
    end
  end

  // FSM, wait/drain counters, sticky flags and saturating stall counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= RUN;
      ret_drain   <= 1'b0;
      wait_cnt    <= 8'd0;
      drain_cnt   <= 4'd0;
      halted_q    <= 1'b0;
      mem_error_q <= 1'b0;
      stall_cnt   <= 32'd0;
    end else begin
      if ((state != HALTED) && !pc_w && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (freeze) begin
        wait_cnt <= wait_nxt;
        if (state != MEM_WAIT) begin
          ret_drain <= (state == DRAIN);
        end
        if (wait_nxt == TIMEOUT) begin
          state       <= HALTED;
          mem_error_q <= 1'b1;
          halted_q    <= 1'b1;
        end else begin
          state <= MEM_WAIT;
        end
      end else if (eff_drain) begin
        drain_cnt <= drain_cnt - 4'd1;
        if (drain_cnt == 4'd1) begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end else begin
          state <= DRAIN;
        end
      end else if (eff_run) begin
        if (halt_accept) begin
          state     <= DRAIN;
          drain_cnt <= DRAIN_INIT;
        end else begin
          state <= RUN;
        end
      end
    end
  end

  // Combinational controls are forced low while reset is held
  assign bus.pc_write     = rst_b & pc_w;
  assign bus.if_id_write  = rst_b & if_id_w;
  assign bus.if_id_flush  = rst_b & if_id_f;
  assign bus.id_ex_write  = rst_b & id_ex_w;
  assign bus.id_ex_bubble = rst_b & id_ex_b;
  assign bus.back_write   = rst_b & back_w;
  assign bus.halted       = halted_q;
  assign bus.mem_error    = mem_error_q;
  assign bus.stall_count  = stall_cnt;

endmodule
